memory: RTL and testbench
=========================

MEMORY -- requirements
Module: memory

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 0, maximum cycles in WAIT before bus_err is raised; 0 disables the timeout.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 dataE  input  execute_data_t  execute-stage result: pc, alu_out (address or result), srcb (store data), dst, ctl, valid.
REQ-005 stall_ext  input  1  a later stage cannot accept dataM this cycle.
REQ-006 flush  input  1  kill the in-flight instruction.
REQ-007 dreq  output  dbus_req_t  data-bus request: valid, addr, size, strobe, data.
REQ-008 dresp  input  dbus_resp_t  data-bus response: addr_ok, data_ok, data.
REQ-009 dataM  output  memory_data_t  pc, dst, ctl, valid, result (load data or alu_out).
REQ-010 stallM  output  1  memory stage busy; upstream registers hold.
REQ-011 bus_err  output  1  one-cycle pulse on timeout or misalignment.

Function
REQ-012 FSM states: IDLE, WAIT, HOLD, DRAIN.
REQ-013 IDLE: dataE.valid with ctl.memRead or ctl.memWrite asserts dreq.valid combinationally in that cycle and enters WAIT next cycle unless dresp.data_ok arrives in the same cycle.
REQ-014 Non-memory valid instruction passes through with zero added latency: dataM.result = alu_out, stallM = 0.
REQ-015 dreq.addr, size, strobe and data SHALL stay stable from first assertion until the data_ok cycle; dreq.valid drops the cycle after data_ok.
REQ-016 size is taken from ctl.msize (1/2/4/8 bytes); strobe = size mask shifted by addr[2:0]; data = srcb shifted left by 8*addr[2:0].
REQ-017 Load result = dresp.data shifted right by 8*addr[2:0], truncated to size, sign-extended unless ctl.memUnsigned; word loads sign-extend bit 31 to 64 bits.
REQ-018 stallM = 1 while a memory op is pending without data_ok, and 0 in the data_ok cycle.
REQ-019 data_ok with stall_ext = 0 → dataM is valid in that cycle; next state IDLE.
REQ-020 data_ok with stall_ext = 1 → latch the formatted result, enter HOLD, drive it on dataM, stallM = 0; leave HOLD for IDLE on the first cycle with stall_ext = 0.
REQ-021 flush in IDLE or HOLD → dataM.valid = 0 that cycle; state IDLE.
REQ-022 flush in WAIT → enter DRAIN; keep dreq stable until data_ok; discard the data; return to IDLE; dataM.valid = 0 throughout.
REQ-023 TIMEOUT_CYCLES > 0: a counter clears on entering WAIT and increments each WAIT cycle; on reaching TIMEOUT_CYCLES, pulse bus_err for one cycle and stay in WAIT (request kept).
REQ-024 data_ok in the same cycle as the timeout → the data is accepted and bus_err = 0.

Reset
REQ-025 On reset: state IDLE, dreq.valid = 0, dataM.valid = 0, stallM = 0, bus_err = 0, counter and hold buffer = 0.
REQ-026 Reset asserted mid-WAIT abandons the transaction immediately; no DRAIN.

Configuration
REQ-027 With MEMORY_MISALIGN_CHECK_EN defined: an access with addr not aligned to size issues no dreq, pulses bus_err, and produces dataM.valid = 1 with ctl.exception set and zero latency.
REQ-028 Without MEMORY_MISALIGN_CHECK_EN: misaligned accesses are issued unchanged and bus_err is driven only by the timeout.

Verification
REQ-029 ld at addr 0x80000008, data_ok after 3 cycles carrying 0x1122334455667788 → stallM high for 3 cycles; result 0x1122334455667788.
REQ-030 lb at addr 0x80000003, dresp.data 0x00000000_80000000 → strobe 0x08; result 0xFFFFFFFFFFFFFF80; with lbu, result 0x80.
REQ-031 sh at addr 0x80000006, srcb 0xABCD → strobe 0xC0; dreq.data 0xABCD000000000000.
REQ-032 data_ok arrives while stall_ext is high for 2 cycles → HOLD for 2 cycles; dataM stable; then IDLE.
REQ-033 flush 1 cycle after lw issue, data_ok 4 cycles later → DRAIN; no valid dataM; request stable until data_ok.
REQ-034 TIMEOUT_CYCLES=8, no data_ok → bus_err single pulse on cycle 8 of WAIT; with MEMORY_MISALIGN_CHECK_EN, lw at 0x…2 → bus_err and no dreq.valid.

Source files
------------

// File: rtl/memory.sv
// Memory stage: issues data-bus requests, formats load results, and holds/drains around stalls and flushes.
// Optional build macro MEMORY_MISALIGN_CHECK_EN traps misaligned accesses instead of issuing them.
package memory_pkg;
    typedef enum logic [1:0] {MSIZE_1 = 2'd0, MSIZE_2 = 2'd1, MSIZE_4 = 2'd2, MSIZE_8 = 2'd3} msize_t;

    typedef struct packed {
        logic   memRead;
        logic   memWrite;
        logic   memUnsigned;
        msize_t msize;
        logic   exception;
    } ctl_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] alu_out;
        logic [63:0] srcb;
        logic [4:0]  dst;
        ctl_t        ctl;
        logic        valid;
    } execute_data_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [4:0]  dst;
        ctl_t        ctl;
        logic        valid;
        logic [63:0] result;
    } memory_data_t;

    // Request fields for an instruction; valid is left to the caller.
    function automatic dbus_req_t build_req(execute_data_t e);
        dbus_req_t  r;
        logic [7:0] mask;
        logic [2:0] off;
        off = e.alu_out[2:0];
        case (e.ctl.msize)
            MSIZE_1: mask = 8'h01;
            MSIZE_2: mask = 8'h03;
            MSIZE_4: mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        r.valid  = 1'b0;
        r.addr   = e.alu_out;
        r.size   = e.ctl.msize;
        r.strobe = mask << off;
        r.data   = e.srcb << {off, 3'b000};
        return r;
    endfunction

    function automatic logic [63:0] format_load(ctl_t c, logic [2:0] off, logic [63:0] raw);
        logic [63:0] s;
        s = raw >> {off, 3'b000};
        case (c.msize)
            MSIZE_1: format_load = c.memUnsigned ? {56'd0, s[7:0]}  : {{56{s[7]}},  s[7:0]};
            MSIZE_2: format_load = c.memUnsigned ? {48'd0, s[15:0]} : {{48{s[15]}}, s[15:0]};
            MSIZE_4: format_load = c.memUnsigned ? {32'd0, s[31:0]} : {{32{s[31]}}, s[31:0]};
            default: format_load = s;
        endcase
    endfunction
endpackage

module memory
    import memory_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  execute_data_t dataE,
    input  logic          stall_ext,
    input  logic          flush,
    output dbus_req_t     dreq,
    input  dbus_resp_t    dresp,
    output memory_data_t  dataM,
    output logic          stallM,
    output logic          bus_err
);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD, DRAIN} state_t;

    state_t        state, state_next;
    execute_data_t inst_q;
    memory_data_t  hold_q;
    logic [CW-1:0] wait_cnt;

    execute_data_t cur;
    memory_data_t  fmt;
    logic          is_mem, misalign, issue, bus_active, timeout;
    logic          unused_resp;

    // addr_ok carries no information here: the request is held until data_ok regardless.
    assign unused_resp = dresp.addr_ok;

    assign is_mem = dataE.valid && (dataE.ctl.memRead || dataE.ctl.memWrite);

`ifdef MEMORY_MISALIGN_CHECK_EN
    logic [3:0] span;
    assign span     = 4'd1 << dataE.ctl.msize;
    assign misalign = is_mem && !flush && |(dataE.alu_out[2:0] & (span[2:0] - 3'd1));
`else
    assign misalign = 1'b0;
`endif

    assign issue      = (state == IDLE) && is_mem && !flush && !misalign;
    assign bus_active = issue || (state == WAIT) || (state == DRAIN);
    assign timeout    = (TIMEOUT_CYCLES > 0) && (state == WAIT) &&
                        (int'(wait_cnt) == TIMEOUT_CYCLES - 1);

    // The instruction owning the bus: live from execute in IDLE, captured copy afterwards.
    assign cur = (state == IDLE) ? dataE : inst_q;

    always_comb begin
        fmt.pc     = cur.pc;
        fmt.dst    = cur.dst;
        fmt.ctl    = cur.ctl;
        fmt.valid  = 1'b1;
        fmt.result = cur.ctl.memRead ? format_load(cur.ctl, cur.alu_out[2:0], dresp.data)
                                     : cur.alu_out;
    end

    always_comb begin
        dreq       = build_req(cur);
        dreq.valid = bus_active;
    end

    // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: each combinational block assigns defaults first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (issue) state_next = !dresp.data_ok ? WAIT : (stall_ext ? HOLD : IDLE);
            WAIT: begin
                if (flush)              state_next = dresp.data_ok ? IDLE : DRAIN;
                else if (dresp.data_ok) state_next = stall_ext ? HOLD : IDLE;
            end
            HOLD:  if (flush || !stall_ext) state_next = IDLE;
            DRAIN: if (dresp.data_ok) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        dataM   = '0;
        stallM  = 1'b0;
        bus_err = 1'b0;
        case (state)
            IDLE: begin
                dataM = fmt;
                if (issue) begin
                    dataM.valid = dresp.data_ok;
                    stallM      = !dresp.data_ok;
                end else if (misalign) begin
                    dataM.result        = dataE.alu_out;
                    dataM.ctl.exception = 1'b1;
                    bus_err             = 1'b1;
                end else begin
                    dataM.valid = dataE.valid && !flush;
                end
            end
            WAIT: begin
                dataM       = fmt;
                dataM.valid = dresp.data_ok && !flush;
                stallM      = !dresp.data_ok;
                bus_err     = timeout && !dresp.data_ok;
            end
            HOLD: begin
                dataM       = hold_q;
                dataM.valid = !flush;
            end
            DRAIN: stallM = !dresp.data_ok;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_q   <= '0;
            hold_q   <= '0;
            wait_cnt <= '0;
        end else begin
            if (issue) inst_q <= dataE;
            if (state != HOLD && state_next == HOLD) hold_q <= fmt;
            // Saturates at the limit so the timeout pulse fires only once per wait.
            if (state != WAIT)
                wait_cnt <= '0;
            else if (int'(wait_cnt) < TIMEOUT_CYCLES)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_memory.sv
// Scoreboard bench for memory: stimulus queues expected requests/results; a negedge monitor compares.
module tb_memory;
    import memory_pkg::*;

    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    execute_data_t dataE;
    logic          stall_ext, flush;
    dbus_req_t     dreq;
    dbus_resp_t    dresp;
    memory_data_t  dataM;
    logic          stallM, bus_err;

    logic          exp_stall, exp_err;
    memory_data_t  exp_q[$];
    dbus_req_t     req_q[$];
    int            n_cmp = 0;
    int            n_err = 0;

    memory #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .dataE(dataE), .stall_ext(stall_ext), .flush(flush),
        .dreq(dreq), .dresp(dresp), .dataM(dataM), .stallM(stallM), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [255:0] got, logic [255:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference: pick the accessed bytes out of the bus word, then extend.
    function automatic logic [63:0] ref_load(logic [63:0] d, int off, int n, bit uns);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++)
            if (off + i < 8) v[8*i +: 8] = d[8*(off+i) +: 8];
        if (!uns && n < 8 && v[8*n-1])
            for (int b = 8 * n; b < 64; b++) v[b] = 1'b1;
        return v;
    endfunction

    function automatic dbus_req_t ref_req(execute_data_t e);
        dbus_req_t r;
        int n   = 1 << int'(e.ctl.msize);
        int off = int'(e.alu_out[2:0]);
        r.valid  = 1'b1;
        r.addr   = e.alu_out;
        r.size   = e.ctl.msize;
        r.strobe = '0;
        for (int i = 0; i < n; i++)
            if (off + i < 8) r.strobe[off+i] = 1'b1;
        r.data   = e.srcb << (8 * off);
        return r;
    endfunction

    function automatic execute_data_t mk_op(logic [63:0] addr, logic [63:0] srcb, bit rd, bit wr,
                                            bit uns, msize_t sz);
        execute_data_t e;
        e.pc = {$urandom, $urandom};
        e.alu_out = addr;
        e.srcb = srcb;
        e.dst = 5'($urandom);
        e.ctl.memRead = rd;
        e.ctl.memWrite = wr;
        e.ctl.memUnsigned = uns;
        e.ctl.msize = sz;
        e.ctl.exception = 1'b0;
        e.valid = 1'b1;
        return e;
    endfunction

    function automatic execute_data_t rand_op();
        execute_data_t e;
        int k = $urandom_range(0, 2);
        int sz = $urandom_range(0, 3);
        int off = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7)
                                               : ($urandom_range(0, 7) & ~((1 << sz) - 1));
        e = mk_op(64'h8000_0000 + 64'($urandom_range(0, 255) * 8 + off), {$urandom, $urandom},
                  k == 1, k == 2, 1'($urandom), msize_t'(sz));
        if (k == 0) e.alu_out = {$urandom, $urandom};
        return e;
    endfunction

    function automatic execute_data_t bubble();
        execute_data_t e = rand_op();
        e.valid = 1'b0;
        return e;
    endfunction

    task automatic step(execute_data_t e, bit ok, logic [63:0] rd, bit st, bit fl, bit es, bit ee);
        dataE = e;
        dresp.data_ok = ok;
        dresp.addr_ok = ok;
        dresp.data = rd;
        stall_ext = st;
        flush = fl;
        exp_stall = es;
        exp_err = ee;
        @(posedge clk);
        #1;
    endtask

    // One instruction: data_ok `lat` cycles after issue, then `hold` cycles of stall_ext.
    task automatic run_op(execute_data_t e, int lat, int hold, logic [63:0] rdata);
        memory_data_t m;
        bit mem = e.ctl.memRead || e.ctl.memWrite;
        bit mis = 1'b0;
        int n = 1 << int'(e.ctl.msize);
        int off = int'(e.alu_out[2:0]);
        int last;
`ifdef MEMORY_MISALIGN_CHECK_EN
        mis = mem && (off % n != 0);
`endif
        m.pc = e.pc;
        m.dst = e.dst;
        m.ctl = e.ctl;
        m.valid = 1'b1;
        m.result = (mem && e.ctl.memRead && !mis) ? ref_load(rdata, off, n, e.ctl.memUnsigned)
                                                  : e.alu_out;
        if (mis) begin
            m.ctl.exception = 1'b1;
            mem = 1'b0;
        end
        if (mem) req_q.push_back(ref_req(e));
        exp_q.push_back(m);
        last = mem ? lat : 0;
        for (int c = 0; c <= last + hold; c++)
            step(e, mem && c == lat, (mem && c == lat) ? rdata : {$urandom, $urandom},
                 (c < last) ? 1'($urandom) : (c < last + hold), 1'b0,
                 mem && c < lat, mis ? (c == 0) : (mem && c == TO && c < lat));
    endtask

    // Monitor: compare outputs at negedge against queued expectations.
    always @(negedge clk) begin
        if (!reset) begin
            check("stallM", 256'(stallM), 256'(exp_stall));
            check("bus_err", 256'(bus_err), 256'(exp_err));
            if (flush)
                check("dataM_valid_on_flush", 256'(dataM.valid), 256'(0));
            else if (dataM.valid) begin
                if (exp_q.size() == 0)
                    check("dataM_unexpected", 256'(dataM.valid), 256'(0));
                else begin
                    check("dataM", 256'(dataM), 256'(exp_q[0]));
                    if (!stall_ext) void'(exp_q.pop_front());
                end
            end
            if (req_q.size() > 0) begin
                check("dreq", 256'(dreq), 256'(req_q[0]));
                if (dresp.data_ok) void'(req_q.pop_front());
            end else
                check("dreq_idle_valid", 256'(dreq.valid), 256'(0));
        end
    end

    initial begin
        execute_data_t e;
        reset = 1'b1;
        dataE = '0;
        dresp = '0;
        stall_ext = 1'b0;
        flush = 1'b0;
        exp_stall = 1'b0;
        exp_err = 1'b0;
        #2;
        check("reset_dreq_valid", 256'(dreq.valid), 256'(0));
        check("reset_dataM_valid", 256'(dataM.valid), 256'(0));
        check("reset_stallM", 256'(stallM), 256'(0));
        check("reset_bus_err", 256'(bus_err), 256'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(bubble(), 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

        // ld, lb/lbu, sh, lw with external hold, and a misaligned lw
        run_op(mk_op(64'h8000_0008, '0, 1, 0, 0, MSIZE_8), 3, 0, 64'h1122_3344_5566_7788);
        run_op(mk_op(64'h8000_0003, '0, 1, 0, 0, MSIZE_1), 1, 0, 64'h0000_0000_8000_0000);
        run_op(mk_op(64'h8000_0003, '0, 1, 0, 1, MSIZE_1), 1, 0, 64'h0000_0000_8000_0000);
        run_op(mk_op(64'h8000_0006, 64'hABCD, 0, 1, 0, MSIZE_2), 2, 0, '0);
        run_op(mk_op(64'h8000_0004, '0, 1, 0, 0, MSIZE_4), 1, 2, 64'h8765_4321_F000_0001);
        run_op(mk_op(64'h8000_0010, '0, 1, 0, 0, MSIZE_4), 0, 2, 64'h0000_0000_7FFF_FFFF);
        run_op(mk_op(64'h8000_0002, '0, 1, 0, 0, MSIZE_4), 2, 0, {$urandom, $urandom});

        // Timeout pulse on WAIT cycle 8, and data_ok coinciding with the timeout
        run_op(mk_op(64'h8000_0020, '0, 1, 0, 0, MSIZE_8), 12, 0, {$urandom, $urandom});
        run_op(mk_op(64'h8000_0028, '0, 1, 0, 1, MSIZE_4), TO, 0, {$urandom, $urandom});

        // Flush while waiting: drained, nothing reaches dataM
        e = mk_op(64'h8000_0010, '0, 1, 0, 0, MSIZE_4);
        req_q.push_back(ref_req(e));
        step(e, 1'b0, {$urandom, $urandom}, 1'b0, 1'b0, 1'b1, 1'b0);
        step(bubble(), 1'b0, {$urandom, $urandom}, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(bubble(), 1'b0, {$urandom, $urandom}, 1'b0, 1'b0, 1'b1, 1'b0);
        step(bubble(), 1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0, 1'b0);
        step(bubble(), 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Flush while holding a finished load
        e = mk_op(64'h8000_0030, '0, 1, 0, 0, MSIZE_8);
        req_q.push_back(ref_req(e));
        exp_q.push_back('{pc: e.pc, dst: e.dst, ctl: e.ctl, valid: 1'b1, result: 64'h55AA_1234_0000_9999});
        step(e, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(e, 1'b1, 64'h55AA_1234_0000_9999, 1'b1, 1'b0, 1'b0, 1'b0);
        step(e, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(e, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        step(bubble(), 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Flush of a non-memory instruction in IDLE
        e = rand_op();
        e.ctl.memRead = 1'b0;
        e.ctl.memWrite = 1'b0;
        step(e, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset mid-WAIT abandons the transaction
        e = mk_op(64'h8000_0040, '0, 1, 0, 0, MSIZE_8);
        req_q.push_back(ref_req(e));
        step(e, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(e, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        dataE = '0;
        dresp = '0;
        #1;
        check("midwait_reset_dreq_valid", 256'(dreq.valid), 256'(0));
        check("midwait_reset_stallM", 256'(stallM), 256'(0));
        check("midwait_reset_dataM_valid", 256'(dataM.valid), 256'(0));
        req_q.delete();
        exp_stall = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(bubble(), 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(bubble(), 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            run_op(rand_op(), $urandom_range(0, 4),
                   ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0, {$urandom, $urandom});
            for (int b = $urandom_range(0, 2); b > 0; b--)
                step(bubble(), 1'b0, {$urandom, $urandom}, 1'($urandom), 1'b0, 1'b0, 1'b0);
        end

        step(bubble(), 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(bubble(), 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("results_outstanding", 256'(exp_q.size()), 256'(0));
        check("requests_outstanding", 256'(req_q.size()), 256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
